// File: rtl/qep_encoder_emulator.sv
// Quadrature A/B/Z generator walking emu_pos one x4 count per MIN_EDGE_CLKS toward the accepted target.
// First edge MIN_EDGE_CLKS clocks after accept; tgt_ready = enable, and enable=0 freezes all state.
module qep_encoder_emulator #(
    parameter int CPR           = 1024,
    parameter int MIN_EDGE_CLKS = 100
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic signed [31:0] tgt_pos,
    input  logic               tgt_valid,
    output logic               tgt_ready,
    output logic               qep_a,
    output logic               qep_b,
    output logic               qep_z,
    output logic signed [31:0] emu_pos,
    output logic               busy,
    output logic               done
);

    localparam int CPR4  = 4 * CPR;
    localparam int IDX_W = $clog2(CPR4);
    localparam int GAP_W = $clog2(MIN_EDGE_CLKS);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t             state_q;
    logic signed [31:0] pos_q;
    logic signed [31:0] tgt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic               a_q, b_q, z_q, done_q;

    logic               step_fire;
    logic               dir_up;
    logic signed [31:0] pos_d;
    logic [IDX_W-1:0]   idx_d;

    assign step_fire = enable && (state_q == MOVE) && (gap_q == GAP_W'(MIN_EDGE_CLKS - 1));
    // Signed 32-bit compare cannot wrap, so it gives the true direction to the target.
    assign dir_up    = (tgt_q > pos_q);

    always_comb begin
        pos_d = pos_q;
        idx_d = idx_q;
        if (dir_up) begin
            pos_d = pos_q + 32'sd1;
            idx_d = (idx_q == IDX_W'(CPR4 - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            pos_d = pos_q - 32'sd1;
            idx_d = (idx_q == '0) ? IDX_W'(CPR4 - 1) : idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            z_q     <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (enable) begin
                case (state_q)
                    IDLE: begin
                        if (tgt_valid) begin
                            tgt_q <= tgt_pos;
                            gap_q <= '0;
                            if (tgt_pos != pos_q) begin
                                state_q <= MOVE;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    MOVE: begin
                        if (step_fire) begin
                            gap_q <= '0;
                            pos_q <= pos_d;
                            idx_q <= idx_d;
                            a_q   <= idx_d[1] ^ idx_d[0];
                            b_q   <= idx_d[1];
                            z_q   <= (idx_d == '0);
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                        // A step on the accept cycle uses the old target; arrival is judged against the new one.
                        if (tgt_valid) begin
                            tgt_q <= tgt_pos;
                            if (tgt_pos == (step_fire ? pos_d : pos_q)) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end else if (step_fire && (pos_d == tgt_q)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tgt_ready = enable;
    assign qep_a     = a_q;
    assign qep_b     = b_q;
    assign qep_z     = z_q;
    assign emu_pos   = pos_q;
    assign busy      = (state_q == MOVE);
    assign done      = done_q;

endmodule

// File: tb/tb_qep_encoder_emulator.sv
// Directed and random checks of the QEP emulator against a position model and a quadrature decoder.
module tb_qep_encoder_emulator;

    localparam int MIN  = 4;
    localparam int CPR  = 2;
    localparam int CPR4 = 4 * CPR;

    logic               clk       = 1'b0;
    logic               reset_n   = 1'b0;
    logic               enable    = 1'b1;
    logic signed [31:0] tgt_pos   = '0;
    logic               tgt_valid = 1'b0;
    logic               tgt_ready;
    logic               qep_a, qep_b, qep_z;
    logic signed [31:0] emu_pos;
    logic               busy, done;

    int errors = 0;
    int checks = 0;

    int dec_cnt     = 0;
    int spacing_err = 0;
    int bad_seq     = 0;
    int neg_cyc     = 0;
    int last_edge   = -1000;
    int done_cnt    = 0;
    logic [1:0] prev_ab = 2'b00;

    qep_encoder_emulator #(.CPR(CPR), .MIN_EDGE_CLKS(MIN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .tgt_pos   (tgt_pos),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .qep_a     (qep_a),
        .qep_b     (qep_b),
        .qep_z     (qep_z),
        .emu_pos   (emu_pos),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Expected (A,B) for a position: up-count order 00,10,11,01.
    function automatic logic [1:0] model_ab(int pos);
        case (pos & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic model_z(int pos);
        return (pos % CPR4) == 0;
    endfunction

    function automatic int ph_of(logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Independent quadrature decoder and edge-spacing monitor.
    always @(negedge clk) begin
        int d;
        neg_cyc = neg_cyc + 1;
        if (!reset_n) begin
            dec_cnt   = 0;
            prev_ab   = 2'b00;
            last_edge = -1000;
        end else begin
            if ({qep_a, qep_b} != prev_ab) begin
                d = (ph_of({qep_a, qep_b}) - ph_of(prev_ab)) & 3;
                if (d == 1)      dec_cnt = dec_cnt + 1;
                else if (d == 3) dec_cnt = dec_cnt - 1;
                else             bad_seq = bad_seq + 1;
                if (neg_cyc - last_edge < MIN) spacing_err = spacing_err + 1;
                last_edge = neg_cyc;
                prev_ab   = {qep_a, qep_b};
            end
            if (done) done_cnt = done_cnt + 1;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(string tag, int pos);
        chk({tag, "_pos"}, emu_pos, pos);
        chk({tag, "_ab"}, {qep_a, qep_b}, model_ab(pos));
        chk({tag, "_z"}, qep_z, model_z(pos));
    endtask

    task automatic accept(int t);
        tgt_pos   = t;
        tgt_valid = 1'b1;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    task automatic wait_done(int bound);
        for (int i = 0; i < bound && !done; i++) tick(1);
        chk("done_wait", done, 1);
    endtask

    initial begin
        int d0;
        int mpos;
        int delta;

        tick(3);
        chk_state("reset", 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset_n = 1'b1;
        tick(1);

        // Forward 0 -> 8
        accept(8);
        for (int k = 1; k <= 8; k++) begin
            tick(MIN - 1);
            chk_state("fwd_hold", k - 1);
            tick(1);
            chk_state("fwd_step", k);
            if (k < 8) chk("fwd_busy", busy, 1);
        end
        chk("fwd_done", done, 1);
        chk("fwd_idle", busy, 0);
        tick(1);
        chk("fwd_done_pulse", done, 0);

        // Target equal to current position
        accept(8);
        chk("same_done", done, 1);
        chk("same_busy", busy, 0);
        tick(1);
        chk("same_done_pulse", done, 0);
        chk_state("same", 8);

        // Reset asserted mid-move
        accept(20);
        tick(10);
        reset_n = 1'b0;
        #1;
        chk_state("rst_mid", 0);
        chk("rst_mid_busy", busy, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk_state("rst_after", 0);

        // Reverse across zero
        d0 = done_cnt;
        accept(-3);
        for (int k = 1; k <= 3; k++) begin
            tick(MIN);
            chk_state("rev", -k);
        end
        chk("rev_done", done, 1);
        tick(2);
        chk("rev_done_count", done_cnt - d0, 1);

        // Retarget mid-move
        d0 = done_cnt;
        accept(100);
        tick(8 * MIN);
        chk_state("rt_at5", 5);
        tick(2);
        accept(2);
        chk_state("rt_hold", 5);
        tick(1);
        chk_state("rt_step", 4);
        tick(MIN);
        chk_state("rt_step", 3);
        tick(MIN);
        chk_state("rt_end", 2);
        chk("rt_done", done, 1);
        chk("rt_busy", busy, 0);
        tick(2);
        chk("rt_done_count", done_cnt - d0, 1);

        // Freeze mid-gap
        accept(6);
        tick(2);
        enable    = 1'b0;
        tgt_pos   = 50;
        tgt_valid = 1'b1;
        tick(1);
        chk("frz_ready", tgt_ready, 0);
        tick(49);
        chk_state("frz", 2);
        chk("frz_busy", busy, 1);
        tgt_valid = 1'b0;
        enable    = 1'b1;
        tick(1);
        chk_state("frz_resume_hold", 2);
        tick(1);
        chk_state("frz_resume_step", 3);
        wait_done(4 * MIN);
        chk_state("frz_end", 6);

        // Random loopback moves
        mpos = 6;
        for (int n = 0; n < 8; n++) begin
            delta = int'($urandom_range(0, 400)) - 200;
            accept(mpos + delta);
            wait_done((delta < 0 ? -delta : delta) * MIN + 10);
            mpos = mpos + delta;
            chk_state("rnd", mpos);
            tick(1);
            chk("rnd_decoder", dec_cnt, mpos);
        end

        chk("edge_spacing", spacing_err, 0);
        chk("quad_sequence", bad_seq, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
